// File: rtl/irrigation_pkg.sv
// Shared state codes, tank-level constants and default timing parameters for irrigation_ctrl.
// Pure declarations; no latency, no flow control.
package irrigation_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_IRRIGATE = 3'd2,
        S_FAULT    = 3'd3
    } state_t;

    localparam logic [1:0] LVL_EMPTY = 2'b00;
    localparam logic [1:0] LVL_FULL  = 2'b11;

    localparam int DEB_CYCLES_DEF    = 8;
    localparam int MIN_ON_CYCLES_DEF = 16;
    localparam int FILL_TIMEOUT_DEF  = 64;

endpackage

// File: rtl/irrigation_ctrl_debounce.sv
// Two-flop synchroniser plus run-length debounce for a slow asynchronous sensor.
// Latency 2 + DEB_CYCLES cycles from d_in change to d_db change; no backpressure.
module input_debounce #(
    parameter int DEB_CYCLES = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic d_in,
    output logic d_db
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] run_cnt;

    // run_cnt counts consecutive synced samples that disagree with d_db
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            run_cnt <= '0;
            d_db    <= 1'b0;
        end else begin
            sync_a <= d_in;
            sync_b <= sync_a;
            if (sync_b == d_db) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(DEB_CYCLES - 1)) begin
                d_db    <= sync_b;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/irrigation_ctrl.sv
// Supervisory irrigation FSM: drives level-counter direction, inlet valve, sprinkler and fill fault.
// Outputs registered from next state (valid first cycle of new state); no backpressure. Option: RAIN_INHIBIT_EN.
module irrigation_ctrl
    import irrigation_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int MIN_ON_CYCLES = MIN_ON_CYCLES_DEF,
    parameter int FILL_TIMEOUT  = FILL_TIMEOUT_DEF
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Q1,
    input  logic       Q0,
    input  logic       dry_in,
    input  logic       rain_in,
    input  logic       fault_clr,
    output logic       Y,
    output logic       inlet_valve,
    output logic       sprinkler,
    output logic       fault,
    output logic [2:0] state_o
);
    localparam int FW = $clog2(FILL_TIMEOUT + 1);
    localparam int OW = $clog2(MIN_ON_CYCLES + 1);

    state_t        state;
    state_t        next_state;
    logic [FW-1:0] fill_tmr;
    logic [OW-1:0] on_tmr;
    logic [1:0]    level;
    logic          dry_db;
    logic          irrigate_ok;
    logic          rain_stop;

    assign level   = {Q1, Q0};
    assign state_o = state;

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dry_db (
        .Clk  (Clk),
        .Rst  (Rst),
        .d_in (dry_in),
        .d_db (dry_db)
    );

`ifdef RAIN_INHIBIT_EN
    logic rain_db;

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rain_db (
        .Clk  (Clk),
        .Rst  (Rst),
        .d_in (rain_in),
        .d_db (rain_db)
    );

    assign irrigate_ok = dry_db && !rain_db;
    assign rain_stop   = rain_db;
`else
    logic rain_unused;

    assign rain_unused = rain_in;
    assign irrigate_ok = dry_db;
    assign rain_stop   = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (level == LVL_EMPTY)
                    next_state = S_FILL;
                else if (irrigate_ok)
                    next_state = S_IRRIGATE;
            end
            S_FILL: begin
                if (level == LVL_FULL)
                    next_state = S_IDLE;
                else if (fill_tmr == FW'(FILL_TIMEOUT - 1))
                    next_state = S_FAULT;
            end
            S_IRRIGATE: begin
                // an empty tank beats every other exit to protect the pump
                if (level == LVL_EMPTY)
                    next_state = S_FILL;
                else if (rain_stop)
                    next_state = S_IDLE;
                else if (!dry_db && (on_tmr >= OW'(MIN_ON_CYCLES - 1)))
                    next_state = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_IDLE;
            fill_tmr    <= '0;
            on_tmr      <= '0;
            Y           <= 1'b0;
            inlet_valve <= 1'b0;
            sprinkler   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state <= next_state;

            // timers sit at zero outside their state, so each starts at 0 on entry
            if (state == S_FILL) begin
                if (fill_tmr != FW'(FILL_TIMEOUT))
                    fill_tmr <= fill_tmr + FW'(1);
            end else begin
                fill_tmr <= '0;
            end

            if (state == S_IRRIGATE) begin
                if (on_tmr != OW'(MIN_ON_CYCLES))
                    on_tmr <= on_tmr + OW'(1);
            end else begin
                on_tmr <= '0;
            end

            case (next_state)
                S_FILL:     Y <= 1'b1;
                S_IRRIGATE: Y <= 1'b0;
                default:    Y <= Y;
            endcase
            inlet_valve <= (next_state == S_FILL);
            sprinkler   <= (next_state == S_IRRIGATE);
            fault       <= (next_state == S_FAULT);
        end
    end

endmodule
